// File: rtl/program_run_controller.sv
// Host-facing run controller. It holds the host-loaded instruction memory and sequences
// run, step, halt, breakpoint, out-of-range trap and cycle limit through core_enable.
module program_run_controller #(
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter int unsigned             PC_WIDTH    = 16,
  parameter int unsigned             IMEM_DEPTH  = 1024,
  parameter int unsigned             CYCLE_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    program_counter,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   core_enable,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [PC_WIDTH-1:0]    load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   cmd_start,
  input  logic                   cmd_step,
  input  logic                   cmd_halt,
  input  logic                   bp_enable,
  input  logic [PC_WIDTH-1:0]    bp_addr,
  input  logic [CYCLE_WIDTH-1:0] cycle_limit,
  output logic                   running,
  output logic                   halted,
  output logic [2:0]             halt_cause,
  output logic [CYCLE_WIDTH-1:0] cycle_count
);

  localparam int unsigned         ADDR_W    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [PC_WIDTH:0]   DEPTH_LIM = (PC_WIDTH+1)'(IMEM_DEPTH);

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_HOST  = 3'd1;
  localparam logic [2:0] CAUSE_BREAK = 3'd2;
  localparam logic [2:0] CAUSE_OOB   = 3'd3;
  localparam logic [2:0] CAUSE_LIMIT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   skip_q;
  logic [2:0]             cause_q;
  logic [CYCLE_WIDTH-1:0] count_q;
  logic [INSTR_WIDTH-1:0] imem_q [IMEM_DEPTH];

  logic in_idle, in_run, in_step, in_halted;
  logic pc_in_range, load_in_range;
  logic oob, brk, lim, stop, count_sat;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_run    = (state_q == ST_RUN);
  assign in_step   = (state_q == ST_STEP);
  assign in_halted = (state_q == ST_HALTED);

  assign pc_in_range   = ({1'b0, program_counter} < DEPTH_LIM);
  assign load_in_range = ({1'b0, load_addr} < DEPTH_LIM);

  // skip lets a resume from HALTED execute the instruction sitting at bp_addr once.
  assign oob       = !pc_in_range;
  assign brk       = bp_enable && (program_counter == bp_addr) && !skip_q;
  assign lim       = (cycle_limit != '0) && (count_q >= cycle_limit);
  assign stop      = oob | brk | lim;
  assign count_sat = &count_q;

  assign core_enable = (in_run && !stop) || in_step;
  assign instruction = (core_enable && pc_in_range) ? imem_q[program_counter[ADDR_W-1:0]]
                                                    : NOP_INSTR;

  assign load_ready  = in_idle | in_halted;
  assign running     = in_run | in_step;
  assign halted      = in_halted;
  assign halt_cause  = cause_q;
  assign cycle_count = count_q;

  // Out-of-range addresses are accepted but never alias onto a real word.
  always_ff @(posedge clk) begin
    if (!rst && load_valid && load_ready && load_in_range) begin
      imem_q[load_addr[ADDR_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      skip_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
      count_q <= '0;
    end else begin
      if (core_enable && !count_sat) begin
        count_q <= count_q + CYCLE_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_start) begin
            state_q <= ST_RUN;
            skip_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            count_q <= '0;
          end else if (cmd_step) begin
            state_q <= ST_STEP;
          end
        end
        ST_RUN: begin
          skip_q <= 1'b0;
          // A stop condition outranks a coincident host halt.
          if (stop) begin
            state_q <= ST_HALTED;
            if (brk)      cause_q <= CAUSE_BREAK;
            else if (oob) cause_q <= CAUSE_OOB;
            else          cause_q <= CAUSE_LIMIT;
          end else if (cmd_halt) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_HOST;
          end
        end
        ST_STEP: begin
          state_q <= ST_HALTED;
          cause_q <= CAUSE_HOST;
        end
        ST_HALTED: begin
          if (cmd_start) begin
            state_q <= ST_RUN;
            skip_q  <= 1'b1;
          end else if (cmd_step) begin
            state_q <= ST_STEP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_run_controller.sv
// Directed plus randomized bench for program_run_controller, checked every cycle against
// a behavioural model of the run/step/halt rules and the instruction memory.
module tb_program_run_controller;

  localparam int          IW    = 32;
  localparam int          PW    = 8;
  localparam int          DEPTH = 16;
  localparam int          CW    = 6;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          SAT   = (1 << CW) - 1;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_STEP = 2;
  localparam int S_HALT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] program_counter;
  logic [IW-1:0] instruction;
  logic          core_enable;
  logic          load_valid;
  logic          load_ready;
  logic [PW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          cmd_start;
  logic          cmd_step;
  logic          cmd_halt;
  logic          bp_enable;
  logic [PW-1:0] bp_addr;
  logic [CW-1:0] cycle_limit;
  logic          running;
  logic          halted;
  logic [2:0]    halt_cause;
  logic [CW-1:0] cycle_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_state;
  int          m_cause;
  int          m_count;
  bit          m_skip;
  logic [31:0] m_mem [DEPTH];

  program_run_controller #(
    .INSTR_WIDTH(IW), .PC_WIDTH(PW), .IMEM_DEPTH(DEPTH), .CYCLE_WIDTH(CW), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .program_counter(program_counter), .instruction(instruction),
    .core_enable(core_enable), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data), .cmd_start(cmd_start), .cmd_step(cmd_step),
    .cmd_halt(cmd_halt), .bp_enable(bp_enable), .bp_addr(bp_addr), .cycle_limit(cycle_limit),
    .running(running), .halted(halted), .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_brk();
    return bp_enable && (program_counter == bp_addr) && !m_skip;
  endfunction

  function automatic bit m_oob();
    return int'(program_counter) >= DEPTH;
  endfunction

  function automatic bit m_lim();
    return (cycle_limit != 0) && (m_count >= int'(cycle_limit));
  endfunction

  function automatic bit m_en();
    if (m_state == S_STEP) return 1'b1;
    if (m_state == S_RUN)  return !(m_brk() || m_oob() || m_lim());
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_instr();
    if (m_en() && !m_oob()) return m_mem[program_counter[3:0]];
    return NOP;
  endfunction

  task automatic check_model();
    check("instruction", instruction, m_instr());
    check("core_enable", 32'(core_enable), 32'(m_en()));
    check("running", 32'(running), 32'(m_state == S_RUN || m_state == S_STEP));
    check("halted", 32'(halted), 32'(m_state == S_HALT));
    check("load_ready", 32'(load_ready), 32'(m_state == S_IDLE || m_state == S_HALT));
    check("halt_cause", 32'(halt_cause), 32'(m_cause));
    check("cycle_count", 32'(cycle_count), 32'(m_count));
  endtask

  // Apply one clock edge to the model, using the inputs held across that edge.
  task automatic m_advance();
    bit en  = m_en();
    bit brk = m_brk();
    bit oob = m_oob();
    bit lim = m_lim();
    if (rst) begin
      m_state = S_IDLE; m_cause = 0; m_count = 0; m_skip = 1'b0;
      return;
    end
    if (load_valid && (m_state == S_IDLE || m_state == S_HALT) && int'(load_addr) < DEPTH)
      m_mem[load_addr[3:0]] = load_data;
    if (en && m_count < SAT) m_count = m_count + 1;
    case (m_state)
      S_IDLE: begin
        if (cmd_start) begin m_state = S_RUN; m_count = 0; m_cause = 0; m_skip = 1'b0; end
        else if (cmd_step) m_state = S_STEP;
      end
      S_RUN: begin
        m_skip = 1'b0;
        if (brk)           begin m_state = S_HALT; m_cause = 2; end
        else if (oob)      begin m_state = S_HALT; m_cause = 3; end
        else if (lim)      begin m_state = S_HALT; m_cause = 4; end
        else if (cmd_halt) begin m_state = S_HALT; m_cause = 1; end
      end
      S_STEP: begin m_state = S_HALT; m_cause = 1; end
      default: begin
        if (cmd_start) begin m_state = S_RUN; m_skip = 1'b1; end
        else if (cmd_step) m_state = S_STEP;
      end
    endcase
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 ns later, then the edge is taken.
  task automatic cycle();
    #1;
    check_model();
    if (rst || load_valid || cmd_start || cmd_step || cmd_halt)
      $display("txn t=%0t rst=%0b start=%0b step=%0b halt=%0b load=%0b addr=%0d data=0x%0h pc=%0d",
               $time, rst, cmd_start, cmd_step, cmd_halt, load_valid, load_addr, load_data,
               program_counter);
    @(posedge clk);
    m_advance();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; program_counter = '0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    cmd_start = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    bp_enable = 1'b0; bp_addr = '0; cycle_limit = '0;
    repeat (2) @(posedge clk);
    m_state = S_IDLE; m_cause = 0; m_count = 0; m_skip = 1'b0;
    @(negedge clk);
    cycle();
    rst = 1'b0;

    // Reset and load
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1;
      load_addr  = PW'(i);
      load_data  = (i < 4) ? 32'(32'h11 * (i + 1)) : 32'(32'h100 + i);
      cycle();
    end
    load_addr = PW'(DEPTH); load_data = 32'hBAD0_BAD0;
    cycle();
    load_valid = 1'b0;
    program_counter = 8'd2;
    #1;
    check("idle_instr", instruction, NOP);
    check("idle_en", 32'(core_enable), 32'd0);
    check("idle_ready", 32'(load_ready), 32'd1);
    cycle();

    // Run and host halt
    cmd_start = 1'b1; cycle(); cmd_start = 1'b0;
    program_counter = 8'd0; #1; check("run_pc0", instruction, 32'h11); cycle();
    program_counter = 8'd1; #1; check("run_pc1", instruction, 32'h22); cycle();
    program_counter = 8'd2; cmd_halt = 1'b1; #1; check("run_pc2", instruction, 32'h33); cycle();
    cmd_halt = 1'b0;
    #1;
    check("host_halted", 32'(halted), 32'd1);
    check("host_cause", 32'(halt_cause), 32'd1);
    check("host_count", 32'(cycle_count), 32'd3);
    check("host_ready", 32'(load_ready), 32'd1);
    cycle();

    // Breakpoint and resume
    bp_enable = 1'b1; bp_addr = 8'd5;
    program_counter = 8'd3; cmd_start = 1'b1; cycle(); cmd_start = 1'b0;
    program_counter = 8'd3; cycle();
    program_counter = 8'd4; cycle();
    program_counter = 8'd5; #1; check("bp_en", 32'(core_enable), 32'd0); cycle();
    #1;
    check("bp_cause", 32'(halt_cause), 32'd2);
    check("bp_count", 32'(cycle_count), 32'd5);
    cmd_start = 1'b1; cycle(); cmd_start = 1'b0;
    #1;
    check("resume_en", 32'(core_enable), 32'd1);
    check("resume_instr", instruction, 32'h105);
    cycle();
    program_counter = 8'd6; cycle();
    #1; check("resume_running", 32'(running), 32'd1);
    program_counter = 8'd5; #1; check("rebreak_en", 32'(core_enable), 32'd0); cycle();
    bp_enable = 1'b0;

    // Single step, then start+step together
    program_counter = 8'd7; cmd_step = 1'b1; cycle(); cmd_step = 1'b0;
    #1;
    check("step_en", 32'(core_enable), 32'd1);
    check("step_instr", instruction, 32'h107);
    cycle();
    #1;
    check("step_halted", 32'(halted), 32'd1);
    check("step_cause", 32'(halt_cause), 32'd1);
    check("step_count", 32'(cycle_count), 32'd8);
    check("step_en_after", 32'(core_enable), 32'd0);
    cmd_start = 1'b1; cmd_step = 1'b1; cycle(); cmd_start = 1'b0; cmd_step = 1'b0;
    program_counter = 8'd8; cycle();
    program_counter = 8'd9; cycle();
    #1;
    check("start_wins_run", 32'(running), 32'd1);
    check("start_wins_halt", 32'(halted), 32'd0);

    // Out-of-range PC trap
    program_counter = PW'(DEPTH);
    #1;
    check("oob_instr", instruction, NOP);
    check("oob_en", 32'(core_enable), 32'd0);
    cycle();
    #1; check("oob_cause", 32'(halt_cause), 32'd3);

    // Reset mid-run, with a load presented during reset
    cmd_start = 1'b1; program_counter = 8'd0; cycle(); cmd_start = 1'b0;
    cycle();
    program_counter = 8'd1; rst = 1'b1; cycle();
    load_valid = 1'b1; load_addr = 8'd1; load_data = 32'h99; cycle();
    rst = 1'b0; load_valid = 1'b0;
    #1;
    check("rst_running", 32'(running), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cause", 32'(halt_cause), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);

    // Cycle limit
    cycle_limit = CW'(4);
    cmd_start = 1'b1; cycle(); cmd_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      program_counter = PW'(k);
      #1;
      if (k == 0) check("mem0_kept", instruction, 32'h11);
      if (k == 1) check("mem1_kept", instruction, 32'h22);
      check("limit_en", 32'(core_enable), 32'(k < 4));
      cycle();
    end
    #1;
    check("limit_cause", 32'(halt_cause), 32'd4);
    check("limit_count", 32'(cycle_count), 32'd4);
    cycle_limit = '0;

    // Counter saturation
    cmd_start = 1'b1; cycle(); cmd_start = 1'b0;
    for (int k = 0; k < 70; k++) begin
      program_counter = PW'(k % DEPTH);
      cycle();
    end
    #1; check("count_sat", 32'(cycle_count), 32'(SAT));
    cmd_halt = 1'b1; cycle(); cmd_halt = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst             = ($urandom_range(0, 49) == 0);
      load_valid      = ($urandom_range(0, 3) == 0);
      load_addr       = PW'($urandom_range(0, DEPTH + 1));
      load_data       = $urandom;
      cmd_start       = ($urandom_range(0, 9) == 0);
      cmd_step        = ($urandom_range(0, 9) == 0);
      cmd_halt        = ($urandom_range(0, 11) == 0);
      bp_enable       = ($urandom_range(0, 1) == 1);
      bp_addr         = PW'($urandom_range(0, DEPTH + 1));
      program_counter = PW'($urandom_range(0, DEPTH + 1));
      if ($urandom_range(0, 19) == 0)
        cycle_limit = ($urandom_range(0, 1) == 0) ? CW'(0) : CW'($urandom_range(1, SAT));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
